// File: rtl/uninasoc_irq_arbiter.sv
// uninasoc_irq_arbiter
//   Scalable interrupt aggregator for the RVM socket core. Each of NUM_IRQ
//   sources is synchronised, latched by an edge- or level-type gateway,
//   masked, and fixed-priority arbitrated (ID 1 highest). The single request
//   line is serviced with a claim/complete handshake, one ID at a time.
//
//   Handshake: irq_o=1 means claim_id_o holds a valid offer. A one-cycle
//   claim_i while irq_o=1 accepts exactly the ID shown on claim_id_o in that
//   cycle. The ID stays on claim_id_o until a one-cycle complete_i arrives
//   with complete_id_i equal to it. Strobes arriving in any other state are
//   ignored.
//
// Ports
//   clock_i        system clock
//   reset_i        synchronous, active-high reset
//   irq_src_i      raw sources, bit i = ID i+1
//   irq_enable_i   per-source enable, already on clock_i
//   irq_o          interrupt request to the core
//   claim_i        claim strobe
//   claim_id_o     offered / in-service ID, 0 = none
//   complete_i     completion strobe
//   complete_id_i  ID being completed
//   pending_o      pending bits (status)

module uninasoc_irq_arbiter #(
  parameter int                 NUM_IRQ     = 3,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 ID_W        = $clog2(NUM_IRQ + 1)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic [NUM_IRQ-1:0] irq_enable_i,
  output logic               irq_o,
  input  logic               claim_i,
  output logic [ID_W-1:0]    claim_id_o,
  input  logic               complete_i,
  input  logic [ID_W-1:0]    complete_id_i,
  output logic [NUM_IRQ-1:0] pending_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NOTIFY  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic               r_irq, w_irq_next;
  logic [ID_W-1:0]    r_claim_id, w_claim_id_next;
  logic [NUM_IRQ-1:0] r_pending, r_prev;
  logic [NUM_IRQ-1:0] w_sync, w_set, w_clr, w_id_match, w_cand;
  logic [ID_W-1:0]    w_win_id;
  logic               w_claim_acc, w_in_service;

  // Synchroniser chain; bypassed when the sources already live on clock_i.
  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign w_sync = irq_src_i;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
      always_ff @(posedge clock_i) begin
        if (reset_i) begin
          for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
          r_sync[0] <= irq_src_i;
          for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
      end
      assign w_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_claim_acc  = (r_state == NOTIFY) && claim_i;
  // The claim-accept cycle already counts as "in service", so a level source
  // that is still high cannot immediately re-set the bit being cleared.
  assign w_in_service = (r_state == SERVICE) || w_claim_acc;

  always_comb begin
    w_id_match = '0;
    w_set      = '0;
    w_clr      = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_id_match[i] = (r_claim_id == ID_W'(i + 1));
      if (EDGE_MASK[i]) w_set[i] = w_sync[i] & ~r_prev[i];
      else              w_set[i] = w_sync[i] & ~(w_in_service & w_id_match[i]);
      w_clr[i] = w_claim_acc & w_id_match[i];
    end
  end

  // Set has priority over clear when both happen in the same cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_prev    <= w_sync;
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  assign w_cand = r_pending & irq_enable_i;

  // Lowest set index wins; scanning downwards leaves the lowest one last.
  always_comb begin
    w_win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win_id = ID_W'(i + 1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_irq      <= 1'b0;
      r_claim_id <= '0;
    end else begin
      r_state    <= w_state_next;
      r_irq      <= w_irq_next;
      r_claim_id <= w_claim_id_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_irq_next      = r_irq;
    w_claim_id_next = r_claim_id;
    case (r_state)
      IDLE: begin
        w_irq_next      = 1'b0;
        w_claim_id_next = '0;
        if (|w_cand) begin
          w_state_next    = NOTIFY;
          w_irq_next      = 1'b1;
          w_claim_id_next = w_win_id;
        end
      end
      NOTIFY: begin
        if (claim_i) begin
          // Accept whatever is currently shown; the ID stays on the output.
          w_state_next = SERVICE;
          w_irq_next   = 1'b0;
        end else if (!(|w_cand)) begin
          w_state_next    = IDLE;
          w_irq_next      = 1'b0;
          w_claim_id_next = '0;
        end else begin
          // Re-offer each cycle so a higher priority or a disable preempts.
          w_irq_next      = 1'b1;
          w_claim_id_next = w_win_id;
        end
      end
      SERVICE: begin
        w_irq_next = 1'b0;
        if (complete_i && (complete_id_i != '0) && (complete_id_i == r_claim_id)) begin
          w_state_next    = IDLE;
          w_claim_id_next = '0;
        end
      end
      default: begin
        w_state_next    = IDLE;
        w_irq_next      = 1'b0;
        w_claim_id_next = '0;
      end
    endcase
  end

  assign irq_o      = r_irq;
  assign claim_id_o = r_claim_id;
  assign pending_o  = r_pending;

endmodule

// File: tb/tb_uninasoc_irq_arbiter.sv
// Bench for uninasoc_irq_arbiter. Two instances share all inputs: one with
// all sources level-type, one with all sources edge-type. Expected claim IDs
// are queued when sources are driven and popped when an offer appears.

module tb_uninasoc_irq_arbiter;

  localparam int N = 3;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] src, en;
  logic         claim, complete;
  logic [W-1:0] complete_id;

  logic         irq_l, irq_e;
  logic [W-1:0] id_l, id_e;
  logic [N-1:0] pend_l, pend_e;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_id;
  int           tests_run    = 0;
  int           tests_failed = 0;

  uninasoc_irq_arbiter #(.NUM_IRQ(N), .EDGE_MASK(3'b000), .SYNC_STAGES(2)) dut_lvl (
    .clock_i(clk), .reset_i(rst), .irq_src_i(src), .irq_enable_i(en),
    .irq_o(irq_l), .claim_i(claim), .claim_id_o(id_l), .complete_i(complete),
    .complete_id_i(complete_id), .pending_o(pend_l)
  );

  uninasoc_irq_arbiter #(.NUM_IRQ(N), .EDGE_MASK(3'b111), .SYNC_STAGES(2)) dut_edg (
    .clock_i(clk), .reset_i(rst), .irq_src_i(src), .irq_enable_i(en),
    .irq_o(irq_e), .claim_i(claim), .claim_id_o(id_e), .complete_i(complete),
    .complete_id_i(complete_id), .pending_o(pend_e)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    src = '0; en = 3'b111; claim = 1'b0; complete = 1'b0; complete_id = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_claim();
    claim = 1'b1; tick(); claim = 1'b0;
  endtask

  task automatic do_complete(input logic [W-1:0] id);
    complete = 1'b1; complete_id = id; tick(); complete = 1'b0; complete_id = '0;
  endtask

  // Waits (bounded) for irq_o of the selected instance; no comparison here.
  task automatic wait_irq(input bit use_edge, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if ((use_edge ? irq_e : irq_l) === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  function automatic logic [W-1:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 'x;
  endfunction

  task automatic test_reset();
    rst = 1'b1; src = '0; en = 3'b111; claim = 1'b0; complete = 1'b0; complete_id = '0;
    tick(); tick();
    tests_run++; if (irq_l !== 1'b0) begin tests_failed++; $display("FAIL reset_irq_l: got %b expected 0", irq_l); end
    tests_run++; if (id_l !== 2'd0) begin tests_failed++; $display("FAIL reset_id_l: got %0d expected 0", id_l); end
    tests_run++; if (pend_l !== 3'b000) begin tests_failed++; $display("FAIL reset_pend_l: got %b expected 000", pend_l); end
    tests_run++; if ({irq_e, id_e, pend_e} !== 6'd0) begin tests_failed++; $display("FAIL reset_edge_outs: got %b expected 000000", {irq_e, id_e, pend_e}); end
    rst = 1'b0;
  endtask

  // T1: latency of a level source through the synchroniser
  task automatic test_latency();
    bit ok;
    do_reset();
    src = 3'b010; exp_q.push_back(2'd2);
    tick(); tick();
    tests_run++; if (pend_l !== 3'b000) begin tests_failed++; $display("FAIL t1_pend_early: got %b expected 000", pend_l); end
    tick();
    tests_run++; if (pend_l !== 3'b010) begin tests_failed++; $display("FAIL t1_pend: got %b expected 010", pend_l); end
    tests_run++; if (irq_l !== 1'b0) begin tests_failed++; $display("FAIL t1_irq_early: got %b expected 0", irq_l); end
    tick();
    tests_run++; if (irq_l !== 1'b1) begin tests_failed++; $display("FAIL t1_irq: got %b expected 1", irq_l); end
    exp_id = pop_exp();
    tests_run++; if (id_l !== exp_id) begin tests_failed++; $display("FAIL t1_id: got %0d expected %0d", id_l, exp_id); end
    do_claim();
    tests_run++; if ({irq_l, id_l, pend_l} !== {1'b0, 2'd2, 3'b000}) begin tests_failed++; $display("FAIL t1_claim: got irq=%b id=%0d pend=%b expected irq=0 id=2 pend=000", irq_l, id_l, pend_l); end
    src = '0;
    wait_irq(1'b0, ok);
    ok = !ok;
    do_complete(2'd2);
    tests_run++; if (id_l !== 2'd0) begin tests_failed++; $display("FAIL t1_complete: got id=%0d expected 0", id_l); end
  endtask

  // T2: two edge sources together, served by priority, back-to-back offer
  task automatic test_back_to_back();
    bit ok;
    do_reset();
    src = 3'b101; exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    tick(); src = '0;
    wait_irq(1'b1, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL t2_irq1: irq_o stayed 0, expected 1 within 20 cycles"); end
    exp_id = pop_exp();
    tests_run++; if (id_e !== exp_id) begin tests_failed++; $display("FAIL t2_id1: got %0d expected %0d", id_e, exp_id); end
    do_claim();
    tests_run++; if ({irq_e, id_e, pend_e} !== {1'b0, 2'd1, 3'b100}) begin tests_failed++; $display("FAIL t2_claim1: got irq=%b id=%0d pend=%b expected irq=0 id=1 pend=100", irq_e, id_e, pend_e); end
    tick();
    tests_run++; if (irq_e !== 1'b0) begin tests_failed++; $display("FAIL t2_service_quiet: got irq=%b expected 0", irq_e); end
    do_complete(2'd1);
    tests_run++; if ({irq_e, id_e} !== {1'b0, 2'd0}) begin tests_failed++; $display("FAIL t2_after_complete: got irq=%b id=%0d expected irq=0 id=0", irq_e, id_e); end
    tick();
    tests_run++; if (irq_e !== 1'b1) begin tests_failed++; $display("FAIL t2_reassert: got irq=%b expected 1", irq_e); end
    exp_id = pop_exp();
    tests_run++; if (id_e !== exp_id) begin tests_failed++; $display("FAIL t2_id2: got %0d expected %0d", id_e, exp_id); end
    do_claim(); do_complete(2'd3);
    tests_run++; if ({id_e, pend_e} !== {2'd0, 3'b000}) begin tests_failed++; $display("FAIL t2_end: got id=%0d pend=%b expected id=0 pend=000", id_e, pend_e); end
  endtask

  // T3: higher priority preempts an unclaimed offer
  task automatic test_preempt();
    bit ok;
    do_reset();
    src = 3'b100;
    wait_irq(1'b0, ok);
    tests_run++; if (!(ok && id_l === 2'd3)) begin tests_failed++; $display("FAIL t3_first_offer: got irq=%b id=%0d expected irq=1 id=3", irq_l, id_l); end
    src = 3'b101; exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    for (int n = 0; n < 8 && id_l === 2'd3; n++) tick();
    exp_id = pop_exp();
    tests_run++; if ({irq_l, id_l} !== {1'b1, exp_id}) begin tests_failed++; $display("FAIL t3_switch: got irq=%b id=%0d expected irq=1 id=%0d", irq_l, id_l, exp_id); end
    do_claim();
    tests_run++; if (id_l !== 2'd1) begin tests_failed++; $display("FAIL t3_claimed: got %0d expected 1", id_l); end
    src = 3'b100; tick(); tick(); tick();
    do_complete(2'd1);
    tick();
    exp_id = pop_exp();
    tests_run++; if ({irq_l, id_l} !== {1'b1, exp_id}) begin tests_failed++; $display("FAIL t3_second: got irq=%b id=%0d expected irq=1 id=%0d", irq_l, id_l, exp_id); end
    src = '0;
  endtask

  // T4: edge re-pend during service, mismatched / zero completes ignored
  task automatic test_edge_repend();
    bit ok;
    do_reset();
    src = 3'b010; exp_q.push_back(2'd2);
    tick(); src = '0;
    wait_irq(1'b1, ok);
    exp_id = pop_exp();
    tests_run++; if (!ok || id_e !== exp_id) begin tests_failed++; $display("FAIL t4_first: got irq=%b id=%0d expected irq=1 id=%0d", irq_e, id_e, exp_id); end
    do_claim();
    tests_run++; if (pend_e !== 3'b000) begin tests_failed++; $display("FAIL t4_cleared: got %b expected 000", pend_e); end
    src = 3'b010; exp_q.push_back(2'd2);
    tick(); src = '0; tick(); tick();
    tests_run++; if ({irq_e, pend_e} !== {1'b0, 3'b010}) begin tests_failed++; $display("FAIL t4_repend: got irq=%b pend=%b expected irq=0 pend=010", irq_e, pend_e); end
    do_complete(2'd3);
    tests_run++; if ({irq_e, id_e} !== {1'b0, 2'd2}) begin tests_failed++; $display("FAIL t4_bad_complete: got irq=%b id=%0d expected irq=0 id=2", irq_e, id_e); end
    do_complete(2'd0);
    do_claim();
    tests_run++; if ({id_e, pend_e} !== {2'd2, 3'b010}) begin tests_failed++; $display("FAIL t4_ignored: got id=%0d pend=%b expected id=2 pend=010", id_e, pend_e); end
    do_complete(2'd2);
    tick();
    exp_id = pop_exp();
    tests_run++; if ({irq_e, id_e} !== {1'b1, exp_id}) begin tests_failed++; $display("FAIL t4_again: got irq=%b id=%0d expected irq=1 id=%0d", irq_e, id_e, exp_id); end
  endtask

  // T5: level re-pend after complete, disable in NOTIFY and in SERVICE
  task automatic test_level_enable();
    bit ok;
    do_reset();
    src = 3'b001; exp_q.push_back(2'd1);
    wait_irq(1'b0, ok);
    exp_id = pop_exp();
    tests_run++; if (!ok || id_l !== exp_id) begin tests_failed++; $display("FAIL t5_first: got irq=%b id=%0d expected irq=1 id=%0d", irq_l, id_l, exp_id); end
    do_claim(); do_complete(2'd1);
    tests_run++; if ({irq_l, pend_l} !== {1'b0, 3'b000}) begin tests_failed++; $display("FAIL t5_complete: got irq=%b pend=%b expected irq=0 pend=000", irq_l, pend_l); end
    tick();
    tests_run++; if (pend_l !== 3'b001) begin tests_failed++; $display("FAIL t5_repend: got %b expected 001", pend_l); end
    exp_q.push_back(2'd1);
    tick();
    exp_id = pop_exp();
    tests_run++; if ({irq_l, id_l} !== {1'b1, exp_id}) begin tests_failed++; $display("FAIL t5_reoffer: got irq=%b id=%0d expected irq=1 id=%0d", irq_l, id_l, exp_id); end
    en = 3'b110; tick();
    tests_run++; if ({irq_l, id_l, pend_l} !== {1'b0, 2'd0, 3'b001}) begin tests_failed++; $display("FAIL t5_disable: got irq=%b id=%0d pend=%b expected irq=0 id=0 pend=001", irq_l, id_l, pend_l); end
    do_claim();
    tests_run++; if ({id_l, pend_l} !== {2'd0, 3'b001}) begin tests_failed++; $display("FAIL t5_idle_claim: got id=%0d pend=%b expected id=0 pend=001", id_l, pend_l); end
    en = 3'b111; tick();
    tests_run++; if ({irq_l, id_l} !== {1'b1, 2'd1}) begin tests_failed++; $display("FAIL t5_reenable: got irq=%b id=%0d expected irq=1 id=1", irq_l, id_l); end
    do_claim(); en = 3'b110; tick();
    tests_run++; if ({irq_l, id_l} !== {1'b0, 2'd1}) begin tests_failed++; $display("FAIL t5_disable_service: got irq=%b id=%0d expected irq=0 id=1", irq_l, id_l); end
    do_complete(2'd1);
    tests_run++; if (id_l !== 2'd0) begin tests_failed++; $display("FAIL t5_end: got id=%0d expected 0", id_l); end
    src = '0; en = 3'b111;
  endtask

  // T6: reset in the middle of service
  task automatic test_reset_service();
    bit ok;
    do_reset();
    src = 3'b010; exp_q.push_back(2'd2);
    tick(); src = '0;
    wait_irq(1'b1, ok);
    exp_id = pop_exp();
    tests_run++; if (!ok || id_e !== exp_id) begin tests_failed++; $display("FAIL t6_offer: got irq=%b id=%0d expected irq=1 id=%0d", irq_e, id_e, exp_id); end
    do_claim();
    rst = 1'b1; tick(); rst = 1'b0;
    tests_run++; if ({irq_e, id_e, pend_e} !== 6'd0) begin tests_failed++; $display("FAIL t6_reset: got %b expected 000000", {irq_e, id_e, pend_e}); end
    do_complete(2'd2); tick();
    tests_run++; if ({irq_e, id_e, pend_e} !== 6'd0) begin tests_failed++; $display("FAIL t6_after: got %b expected 000000", {irq_e, id_e, pend_e}); end
  endtask

  // Random subsets of edge pulses; expected service order is ascending ID.
  task automatic test_random();
    bit ok;
    logic [N-1:0] m;
    logic [W-1:0] cur;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      m = N'($urandom_range(1, 7));
      for (int b = 0; b < N; b++) if (m[b]) exp_q.push_back(W'(b + 1));
      src = m; tick(); src = '0;
      for (int k = 0; k < $countones(m); k++) begin
        wait_irq(1'b1, ok);
        exp_id = pop_exp();
        tests_run++; if (!ok || id_e !== exp_id) begin tests_failed++; $display("FAIL rnd_order: mask=%b got irq=%b id=%0d expected irq=1 id=%0d", m, irq_e, id_e, exp_id); end
        cur = id_e;
        do_claim(); do_complete(cur);
      end
    end
    tests_run++; if (pend_e !== 3'b000 || exp_q.size() != 0) begin tests_failed++; $display("FAIL rnd_drain: got pend=%b left=%0d expected pend=000 left=0", pend_e, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_preempt();
    test_edge_repend();
    test_level_enable();
    test_reset_service();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
